bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_sub3_cell.sv | 16 +
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_pkg;

  // Converter FSM states: idle, shifting, one-cycle completion.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } bcd_state_e;

  // Binary result width; 9999 needs 14 bits.
  localparam int unsigned BinW     = 14;
  // One reverse-double-dabble step per binary result bit.
  localparam int unsigned NumIter  = 14;
  // Largest legal BCD digit.
  localparam int unsigned DigitMax = 9;
  // Four BCD digits.
  localparam int unsigned BcdW     = 16;
  // Iteration counter width, enough for 0..NumIter-1.
  localparam int unsigned CntW     = 4;

  // True when the nibble is not a legal BCD digit.
  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'(DigitMax);
  endfunction

endpackage

// File: rtl/bcd_sub3_cell.sv
// One BCD nibble correction for reverse double dabble: after the right shift,
// a nibble holding 8 or more received a carry-in worth 8 that should be 5.
module bcd_sub3_cell (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Subtract 3 from nibbles of 8 or more, pass the rest through.
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd8) begin
      nib_o = nib_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter using reverse double dabble,
// one shift-and-correct step per clock.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = BinW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       thousands,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf
);

  bcd_state_e state_q, state_d;

  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic [BIN_W-1:0] work_q, work_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [BcdW+BIN_W-1:0] shifted;
  logic [BcdW-1:0]       shifted_bcd;
  logic [BcdW-1:0]       fixed_bcd;
  logic [BIN_W-1:0]      shifted_bin;
  logic                  any_bad;
  logic                  last_step;

  // One step: shift {bcd, binary} right, then correct every BCD nibble.
  always_comb begin
    shifted     = {bcd_q, work_q} >> 1;
    shifted_bcd = shifted[BcdW+BIN_W-1:BIN_W];
    shifted_bin = shifted[BIN_W-1:0];
  end

  for (genvar g = 0; g < 4; g++) begin : g_cell
    bcd_sub3_cell u_cell (
      .nib_i(shifted_bcd[4*g+:4]),
      .nib_o(fixed_bcd[4*g+:4])
    );
  end

  // Request validity and final-step decode.
  always_comb begin
    any_bad   = digit_bad(thousands) | digit_bad(hundreds) |
                digit_bad(tens) | digit_bad(ones);
    last_step = (cnt_q == CntW'(NumIter - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d  = {thousands, hundreds, tens, ones};
          work_d = '0;
          cnt_d  = '0;
          if (any_bad) begin
            // Illegal digit: skip the shifting and report at once.
            state_d = StDone;
            err_d   = 1'b1;
            bin_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = StConv;
            err_d   = 1'b0;
          end
        end
      end
      StConv: begin
        bcd_d  = fixed_bcd;
        work_d = shifted_bin;
        cnt_d  = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          cnt_d   = '0;
          bin_d   = shifted_bin;
          // Results above 8191 do not fit a 13-bit binary-to-BCD path.
          ovf_d   = shifted_bin[BIN_W-1];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy = (state_q == StConv);
    done = (state_q == StDone);
    bin  = bin_q;
    err  = err_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: table of digit sets with expected
// results, scoreboard queue, and hand sequences for reset and back-to-back.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [13:0] bin;
  logic        busy, done, err, ovf;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.BIN_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .thousands(thousands),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ovf      (ovf)
  );

  typedef struct {
    logic [3:0]  d3, d2, d1, d0;
    logic [13:0] bin;
    logic        err;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one request, scramble the digits while it runs, check at done.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    logic busy0;
    @(negedge clk);
    thousands = v.d3; hundreds = v.d2; tens = v.d1; ones = v.d0;
    start = 1'b1;
    e.bin = v.bin; e.err = v.err; e.ovf = v.ovf;
    e.lat = v.err ? 0 : 14;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat   = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      thousands = 4'($urandom); hundreds = 4'($urandom);
      tens      = 4'($urandom); ones     = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " bin"}, 32'(bin), 32'(e.bin));
    chk({tag, " err"}, 32'(err), 32'(e.err));
    chk({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
    chk({tag, " busy after load"}, 32'(busy0), 32'(!e.err));
    @(posedge clk); #1;
    chk({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    int cyc;
    int last;
    int ndone;
    exp_t e;

    vecs[0] = '{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0, 1'b1};
    vecs[1] = '{4'd8, 4'd1, 4'd9, 4'd1, 14'd8191, 1'b0, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0, 1'b0};
    vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0, 1'b0};
    vecs[4] = '{4'd8, 4'd1, 4'd9, 4'd2, 14'd8192, 1'b0, 1'b1};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 14'd1,    1'b0, 1'b0};
    vecs[6] = '{4'd0, 4'd0, 4'hA, 4'd0, 14'd0,    1'b1, 1'b0};
    vecs[7] = '{4'd4, 4'd3, 4'd2, 4'd1, 14'd4321, 1'b0, 1'b0};
    vecs[8] = '{4'hF, 4'd0, 4'd0, 4'd0, 14'd0,    1'b1, 1'b0};
    vecs[9] = '{4'd5, 4'd0, 4'd7, 4'd3, 14'd5073, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bin", 32'(bin), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-conversion when the iteration counter reads 7.
    @(negedge clk);
    thousands = 4'd9; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midconv busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bin", 32'(bin), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no done after rst", 32'(seen), 32'd0);
    run_vec(vecs[3], "post-rst");

    // Start held high: conversions repeat every 16 cycles.
    repeat (3) begin
      e.bin = 14'd1234; e.err = 1'b0; e.ovf = 1'b0; e.lat = 16;
      sb.push_back(e);
    end
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 3 && cyc < 80) begin
      @(negedge clk);
      if (busy) begin
        thousands = 4'($urandom); hundreds = 4'($urandom);
        tens      = 4'($urandom); ones     = 4'($urandom);
      end else begin
        thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; ones = 4'd4;
      end
      start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        e = sb.pop_front();
        if (ndone == 0) chk("held first latency", 32'(cyc - 1), 32'd14);
        else chk($sformatf("held period %0d", ndone), 32'(cyc - last), 32'(e.lat));
        chk($sformatf("held bin %0d", ndone), 32'(bin), 32'(e.bin));
        chk($sformatf("held err %0d", ndone), 32'(err), 32'(e.err));
        last = cyc;
        ndone++;
      end
    end
    chk("held done count", 32'(ndone), 32'd3);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    while ((busy || done) && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
